// File: rtl/encoder_line_trigger_if.sv
// Control, configuration and status bus of the encoder line trigger.
// The slave modport is the trigger's view; the master modport is the controller's.
interface encoder_line_trigger_if #(
   parameter int unsigned POS_W  = 32,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned LINE_W = 16
) ();
   logic [1:0]        enc_pulses_dir;
   logic              pos_clr;
   logic              start;
   logic              abort;
   logic [POS_W-1:0]  cfg_start_pos;
   logic [ACC_W-1:0]  cfg_step;
   logic [LINE_W-1:0] cfg_lines;
   logic              cap_ready;
   logic              trig;
   logic              busy;
   logic              done;
   logic [POS_W-1:0]  pos;
   logic [LINE_W-1:0] line_cnt;
   logic [LINE_W-1:0] missed_cnt;
   logic              overrun;

   modport master (
      output enc_pulses_dir, pos_clr, start, abort, cfg_start_pos, cfg_step, cfg_lines,
             cap_ready,
      input  trig, busy, done, pos, line_cnt, missed_cnt, overrun
   );

   modport slave (
      input  enc_pulses_dir, pos_clr, start, abort, cfg_start_pos, cfg_step, cfg_lines,
             cap_ready,
      output trig, busy, done, pos, line_cnt, missed_cnt, overrun
   );
endinterface

// File: rtl/encoder_line_trigger.sv
// Tracks absolute encoder position and issues one capture trigger every N forward
// steps once a programmed start position is reached.
module encoder_line_trigger #(
   parameter int unsigned POS_W  = 32,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned LINE_W = 16
) (
   input logic                   clk_i,
   input logic                   rst_i,
   encoder_line_trigger_if.slave ctrl_io
);

   typedef enum logic [1:0] {StIdle, StArm, StScan, StDone} state_e;

   localparam logic [POS_W-1:0]  PosOne  = POS_W'(1);
   localparam logic [ACC_W:0]    AccOne  = (ACC_W + 1)'(1);
   localparam logic [LINE_W-1:0] LineOne = LINE_W'(1);
   // Most negative value of an ACC_W-bit signed accumulator, held in ACC_W+1 bits.
   localparam logic [ACC_W:0]    AccMin  = {2'b11, {(ACC_W - 1){1'b0}}};

   state_e            state_q, state_d;
   logic [1:0]        sync1_q, sync2_q, sync3_q, dly_q, strobe_q;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [ACC_W:0]    acc_q, acc_d;
   logic [POS_W-1:0]  start_pos_q, start_pos_d;
   logic [ACC_W-1:0]  step_q, step_d;
   logic [LINE_W-1:0] lines_q, lines_d;
   logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
   logic [LINE_W-1:0] missed_q, missed_d;
   logic              overrun_q, overrun_d;
   logic              trig_q, trig_d;
   logic              busy_q, done_q;

   logic              fwd, rev, issue;
   logic [ACC_W:0]    acc_inc, acc_dec, step_ext;

   // Extra bit keeps the accumulator from wrapping for step values above 2^(ACC_W-1).
   assign fwd      = strobe_q[0] & ~strobe_q[1];
   assign rev      = strobe_q[1] & ~strobe_q[0];
   assign acc_inc  = acc_q + AccOne;
   assign acc_dec  = (acc_q == AccMin) ? acc_q : acc_q - AccOne;
   assign step_ext = (step_q == '0) ? AccOne : {1'b0, step_q};

   always_comb begin
      pos_d       = pos_q;
      acc_d       = acc_q;
      state_d     = state_q;
      start_pos_d = start_pos_q;
      step_d      = step_q;
      lines_d     = lines_q;
      line_cnt_d  = line_cnt_q;
      missed_d    = missed_q;
      overrun_d   = overrun_q;
      trig_d      = 1'b0;
      issue       = 1'b0;

      if (ctrl_io.pos_clr) begin
         pos_d = '0;
      end else if (fwd) begin
         pos_d = pos_q + PosOne;
      end else if (rev) begin
         pos_d = pos_q - PosOne;
      end

      unique case (state_q)
         StIdle: begin
            if (ctrl_io.start) begin
               start_pos_d = ctrl_io.cfg_start_pos;
               step_d      = ctrl_io.cfg_step;
               lines_d     = ctrl_io.cfg_lines;
               line_cnt_d  = '0;
               missed_d    = '0;
               overrun_d   = 1'b0;
               acc_d       = '0;
               state_d     = StArm;
            end
         end
         StArm: begin
            if (ctrl_io.abort) begin
               state_d = StIdle;
            end else if ($signed(pos_d) >= $signed(start_pos_q)) begin
               state_d = StScan;
               acc_d   = '0;
               issue   = 1'b1;
            end
         end
         StScan: begin
            if (ctrl_io.abort) begin
               state_d = StIdle;
            end else if (fwd) begin
               if (acc_inc == step_ext) begin
                  acc_d = '0;
                  issue = 1'b1;
               end else begin
                  acc_d = acc_inc;
               end
            end else if (rev) begin
               acc_d = acc_dec;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (issue) begin
         line_cnt_d = line_cnt_q + LineOne;
         if (ctrl_io.cap_ready) begin
            trig_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
            if (missed_q != '1) begin
               missed_d = missed_q + LineOne;
            end
         end
         if ((lines_q != '0) && (line_cnt_d == lines_q)) begin
            state_d = StDone;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         sync3_q     <= '0;
         dly_q       <= '0;
         strobe_q    <= '0;
         state_q     <= StIdle;
         pos_q       <= '0;
         acc_q       <= '0;
         start_pos_q <= '0;
         step_q      <= '0;
         lines_q     <= '0;
         line_cnt_q  <= '0;
         missed_q    <= '0;
         overrun_q   <= 1'b0;
         trig_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         sync1_q     <= ctrl_io.enc_pulses_dir;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         dly_q       <= sync3_q;
         strobe_q    <= sync3_q & ~dly_q;
         state_q     <= state_d;
         pos_q       <= pos_d;
         acc_q       <= acc_d;
         start_pos_q <= start_pos_d;
         step_q      <= step_d;
         lines_q     <= lines_d;
         line_cnt_q  <= line_cnt_d;
         missed_q    <= missed_d;
         overrun_q   <= overrun_d;
         trig_q      <= trig_d;
         busy_q      <= (state_d == StArm) || (state_d == StScan);
         done_q      <= (state_d == StDone);
      end
   end

   assign ctrl_io.trig       = trig_q;
   assign ctrl_io.busy       = busy_q;
   assign ctrl_io.done       = done_q;
   assign ctrl_io.pos        = pos_q;
   assign ctrl_io.line_cnt   = line_cnt_q;
   assign ctrl_io.missed_cnt = missed_q;
   assign ctrl_io.overrun    = overrun_q;

endmodule

// File: tb/tb_encoder_line_trigger.sv
// Directed bench for encoder_line_trigger: position tracking, arming, line stepping,
// overrun, abort and reset behaviour.
module tb_encoder_line_trigger;
   logic clk;
   logic rst;
   int   checks;
   int   fails;
   int   trig_count;
   int   done_count;

   encoder_line_trigger_if bus ();

   encoder_line_trigger dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .ctrl_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count trigger and done pulses just after each active edge.
   always @(posedge clk) begin
      #1;
      if (bus.trig === 1'b1) trig_count++;
      if (bus.done === 1'b1) done_count++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One encoder pulse; returns at the negedge after POS/TRIG have updated.
   task automatic enc_step(input logic [1:0] bits);
      bus.enc_pulses_dir = bits;
      tick(2);
      bus.enc_pulses_dir = 2'b00;
      tick(3);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic pulse_abort();
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.pos_clr = 1'b1;
      tick(1);
      bus.pos_clr = 1'b0;
   endtask

   task automatic set_cfg(input logic [31:0] sp, input logic [15:0] st, input logic [15:0] ln);
      bus.cfg_start_pos = sp;
      bus.cfg_step      = st;
      bus.cfg_lines     = ln;
   endtask

   task automatic test_reset();
      int t0;
      rst = 1'b1;
      tick(3);
      checks++; if (bus.pos !== 32'd0) begin fails++; $display("FAIL rst_pos: got %0h exp 0", bus.pos); end
      checks++; if (bus.trig !== 1'b0) begin fails++; $display("FAIL rst_trig: got %b exp 0", bus.trig); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b exp 0", bus.done); end
      checks++; if (bus.line_cnt !== 16'd0) begin fails++; $display("FAIL rst_line_cnt: got %0d exp 0", bus.line_cnt); end
      checks++; if (bus.missed_cnt !== 16'd0) begin fails++; $display("FAIL rst_missed: got %0d exp 0", bus.missed_cnt); end
      checks++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b exp 0", bus.overrun); end
      rst = 1'b0;
      tick(1);
      t0 = trig_count;
      repeat (10) enc_step(2'b01);
      checks++; if (bus.pos !== 32'd10) begin fails++; $display("FAIL idle_pos10: got %0d exp 10", bus.pos); end
      checks++; if (trig_count - t0 !== 0) begin fails++; $display("FAIL idle_no_trig: got %0d exp 0", trig_count - t0); end
   endtask

   task automatic test_basic_scan();
      int t0, d0;
      pulse_clr();
      checks++; if (bus.pos !== 32'd0) begin fails++; $display("FAIL clr_pos: got %0d exp 0", bus.pos); end
      set_cfg(32'd0, 16'd4, 16'd3);
      t0 = trig_count;
      d0 = done_count;
      pulse_start();
      checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b exp 1", bus.busy); end
      tick(1);
      checks++; if (trig_count - t0 !== 1) begin fails++; $display("FAIL basic_line0: got %0d exp 1", trig_count - t0); end
      checks++; if (bus.line_cnt !== 16'd1) begin fails++; $display("FAIL basic_lc1: got %0d exp 1", bus.line_cnt); end
      repeat (3) enc_step(2'b01);
      checks++; if (trig_count - t0 !== 1) begin fails++; $display("FAIL basic_p3: got %0d exp 1", trig_count - t0); end
      enc_step(2'b01);
      checks++; if (trig_count - t0 !== 2) begin fails++; $display("FAIL basic_p4: got %0d exp 2", trig_count - t0); end
      repeat (3) enc_step(2'b01);
      checks++; if (trig_count - t0 !== 2) begin fails++; $display("FAIL basic_p7: got %0d exp 2", trig_count - t0); end
      enc_step(2'b01);
      checks++; if (trig_count - t0 !== 3) begin fails++; $display("FAIL basic_p8: got %0d exp 3", trig_count - t0); end
      tick(2);
      checks++; if (done_count - d0 !== 1) begin fails++; $display("FAIL basic_done: got %0d exp 1", done_count - d0); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_idle: got %b exp 0", bus.busy); end
      checks++; if (bus.line_cnt !== 16'd3) begin fails++; $display("FAIL basic_lc3: got %0d exp 3", bus.line_cnt); end
      checks++; if (bus.missed_cnt !== 16'd0) begin fails++; $display("FAIL basic_missed: got %0d exp 0", bus.missed_cnt); end
   endtask

   task automatic test_arm_wait();
      int t0;
      pulse_clr();
      repeat (5) enc_step(2'b10);
      checks++; if (bus.pos !== 32'hFFFF_FFFB) begin fails++; $display("FAIL arm_pos_m5: got %0h exp fffffffb", bus.pos); end
      set_cfg(32'd3, 16'd4, 16'd2);
      pulse_start();
      t0 = trig_count;
      repeat (7) enc_step(2'b01);
      checks++; if (trig_count - t0 !== 0) begin fails++; $display("FAIL arm_no_trig: got %0d exp 0", trig_count - t0); end
      checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL arm_busy: got %b exp 1", bus.busy); end
      checks++; if (bus.pos !== 32'd2) begin fails++; $display("FAIL arm_pos2: got %0d exp 2", bus.pos); end
      enc_step(2'b01);
      checks++; if (trig_count - t0 !== 1) begin fails++; $display("FAIL arm_trig_at3: got %0d exp 1", trig_count - t0); end
      pulse_abort();
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL arm_abort_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.line_cnt !== 16'd1) begin fails++; $display("FAIL arm_abort_lc: got %0d exp 1", bus.line_cnt); end
   endtask

   task automatic test_reverse();
      int t0;
      pulse_clr();
      set_cfg(32'd0, 16'd4, 16'd0);
      pulse_start();
      tick(1);
      t0 = trig_count;
      repeat (2) enc_step(2'b01);
      repeat (3) enc_step(2'b10);
      repeat (4) enc_step(2'b01);
      checks++; if (trig_count - t0 !== 0) begin fails++; $display("FAIL rev_hold: got %0d exp 0", trig_count - t0); end
      enc_step(2'b01);
      checks++; if (trig_count - t0 !== 1) begin fails++; $display("FAIL rev_recover: got %0d exp 1", trig_count - t0); end
      checks++; if (bus.line_cnt !== 16'd2) begin fails++; $display("FAIL rev_lc: got %0d exp 2", bus.line_cnt); end
      pulse_abort();
   endtask

   task automatic test_overrun();
      int t0;
      pulse_clr();
      set_cfg(32'd0, 16'd2, 16'd0);
      bus.cap_ready = 1'b1;
      pulse_start();
      tick(1);
      t0 = trig_count;
      bus.cap_ready = 1'b0;
      repeat (2) enc_step(2'b01);
      checks++; if (trig_count - t0 !== 0) begin fails++; $display("FAIL ovr_no_trig: got %0d exp 0", trig_count - t0); end
      checks++; if (bus.missed_cnt !== 16'd1) begin fails++; $display("FAIL ovr_missed: got %0d exp 1", bus.missed_cnt); end
      checks++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b exp 1", bus.overrun); end
      checks++; if (bus.line_cnt !== 16'd2) begin fails++; $display("FAIL ovr_lc: got %0d exp 2", bus.line_cnt); end
      bus.cap_ready = 1'b1;
      repeat (2) enc_step(2'b01);
      checks++; if (trig_count - t0 !== 1) begin fails++; $display("FAIL ovr_resume: got %0d exp 1", trig_count - t0); end
      checks++; if (bus.line_cnt !== 16'd3) begin fails++; $display("FAIL ovr_lc3: got %0d exp 3", bus.line_cnt); end
      pulse_abort();
      checks++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b exp 1", bus.overrun); end
      pulse_start();
      checks++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL ovr_cleared: got %b exp 0", bus.overrun); end
      checks++; if (bus.missed_cnt !== 16'd0) begin fails++; $display("FAIL ovr_missed_clr: got %0d exp 0", bus.missed_cnt); end
      tick(1);
      checks++; if (bus.line_cnt !== 16'd1) begin fails++; $display("FAIL ovr_restart_lc: got %0d exp 1", bus.line_cnt); end
      pulse_abort();
   endtask

   task automatic test_edge_cases();
      int t0, d0;
      logic [31:0] p;
      logic [15:0] lc;
      p = bus.pos;
      enc_step(2'b11);
      checks++; if (bus.pos !== p) begin fails++; $display("FAIL both_cancel: got %0h exp %0h", bus.pos, p); end
      // Step value of zero behaves as one.
      set_cfg(32'd0, 16'd0, 16'd0);
      pulse_start();
      tick(1);
      t0 = trig_count;
      repeat (3) enc_step(2'b01);
      checks++; if (trig_count - t0 !== 3) begin fails++; $display("FAIL step0_trigs: got %0d exp 3", trig_count - t0); end
      checks++; if (bus.line_cnt !== 16'd4) begin fails++; $display("FAIL step0_lc: got %0d exp 4", bus.line_cnt); end
      // Abort lands on the same edge as a due line.
      t0 = trig_count;
      d0 = done_count;
      p  = bus.pos;
      lc = bus.line_cnt;
      bus.enc_pulses_dir = 2'b01;
      tick(2);
      bus.enc_pulses_dir = 2'b00;
      tick(2);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      checks++; if (trig_count - t0 !== 0) begin fails++; $display("FAIL abort_no_trig: got %0d exp 0", trig_count - t0); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.line_cnt !== lc) begin fails++; $display("FAIL abort_lc_hold: got %0d exp %0d", bus.line_cnt, lc); end
      checks++; if (bus.pos !== p + 32'd1) begin fails++; $display("FAIL abort_pos: got %0d exp %0d", bus.pos, p + 32'd1); end
      checks++; if (done_count - d0 !== 0) begin fails++; $display("FAIL abort_no_done: got %0d exp 0", done_count - d0); end
      // START while armed must not reload config.
      set_cfg(32'd1000, 16'd4, 16'd5);
      pulse_start();
      checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL busy_start_arm: got %b exp 1", bus.busy); end
      set_cfg(32'd0, 16'd1, 16'd0);
      t0 = trig_count;
      pulse_start();
      tick(3);
      enc_step(2'b01);
      checks++; if (trig_count - t0 !== 0) begin fails++; $display("FAIL busy_start_ignored: got %0d exp 0", trig_count - t0); end
      checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL busy_still_arm: got %b exp 1", bus.busy); end
      pulse_abort();
   endtask

   task automatic test_reset_midscan();
      int t0;
      set_cfg(32'd0, 16'd1, 16'd0);
      pulse_start();
      tick(2);
      checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_scan_busy: got %b exp 1", bus.busy); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.pos !== 32'd0) begin fails++; $display("FAIL mid_rst_pos: got %0d exp 0", bus.pos); end
      checks++; if (bus.line_cnt !== 16'd0) begin fails++; $display("FAIL mid_rst_lc: got %0d exp 0", bus.line_cnt); end
      @(negedge clk);
      rst = 1'b0;
      tick(1);
      t0 = trig_count;
      enc_step(2'b01);
      checks++; if (bus.pos !== 32'd1) begin fails++; $display("FAIL mid_post_pos: got %0d exp 1", bus.pos); end
      checks++; if (trig_count - t0 !== 0) begin fails++; $display("FAIL mid_post_trig: got %0d exp 0", trig_count - t0); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_post_busy: got %b exp 0", bus.busy); end
   endtask

   initial begin
      checks             = 0;
      fails              = 0;
      trig_count         = 0;
      done_count         = 0;
      rst                = 1'b1;
      bus.enc_pulses_dir = 2'b00;
      bus.pos_clr        = 1'b0;
      bus.start          = 1'b0;
      bus.abort          = 1'b0;
      bus.cfg_start_pos  = '0;
      bus.cfg_step       = '0;
      bus.cfg_lines      = '0;
      bus.cap_ready      = 1'b1;
      tick(1);
      test_reset();
      test_basic_scan();
      test_arm_wait();
      test_reverse();
      test_overrun();
      test_edge_cases();
      test_reset_midscan();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/encoder_line_trigger.md
Name: encoder_line_trigger

Overview:
- Sequences line-scan acquisition from quadrature-decoded encoder step pulses.
- Tracks absolute position and waits for a programmed start position.
- Then issues one capture trigger every CFG_STEP forward encoder steps for CFG_LINES lines, gated by the capture path's ready flag.
- Sits between the encoder pulse/direction decoder and the line capture/DMA block; configured from the register bank.

Parameters:
- POS_W, 32, width of signed absolute position counter
- ACC_W, 16, width of signed step accumulator and CFG_STEP
- LINE_W, 16, width of line counters and CFG_LINES

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- ENC_PULSES_DIR  in  2  async encoder step pulses; bit0 forward step, bit1 reverse step
- POS_CLR  in  1  sync pulse: clear POS to 0
- START  in  1  sync pulse: latch config, begin scan
- ABORT  in  1  sync pulse: stop scan immediately
- CFG_START_POS  in  POS_W  signed start position
- CFG_STEP  in  ACC_W  unsigned forward steps per line; 0 treated as 1
- CFG_LINES  in  LINE_W  lines per scan; 0 = continuous until ABORT
- CAP_READY  in  1  capture block can accept a trigger
- TRIG  out  1  one-cycle capture trigger
- BUSY  out  1  high in ARM or SCAN
- DONE  out  1  one-cycle pulse on scan completion
- POS  out  POS_W  signed absolute position
- LINE_CNT  out  LINE_W  lines issued this scan (triggered + missed)
- MISSED_CNT  out  LINE_W  lines dropped because CAP_READY was low
- OVERRUN  out  1  sticky: at least one line missed; cleared by START

Behaviour:
- Reset (async, RST=1): all outputs 0, POS 0, accumulator 0, FSM in IDLE, sync registers 0.
- Input path:
  - Each ENC_PULSES_DIR bit passes through 3 sync flops, then a delay flop.
  - A registered rising-edge detect produces inc/dec strobes.
- Latency: input high sampled at edge 1 -> strobe registered at edge 4 -> POS/accumulator/TRIG update at edge 5.
- Simultaneous inc and dec strobes cancel: no POS or accumulator change.
- POS updates in every state: +1 on inc, -1 on dec, two's-complement wrap.
  - POS_CLR takes priority over a same-cycle step.
- FSM states: IDLE, ARM, SCAN, DONE.
- IDLE:
  - START latches CFG_* into shadow registers, clears LINE_CNT, MISSED_CNT, OVERRUN and the accumulator, then goes to ARM.
  - START is ignored in ARM and SCAN.
- ARM: when signed POS (post-update value) >= shadow start position, go to SCAN.
  - If the condition already holds on ARM entry, SCAN is entered the next cycle.
- SCAN entry cycle issues line 0 immediately; the accumulator is set to 0.
- SCAN stepping:
  - Accumulator is signed: +1 on inc, -1 on dec, saturating at -2^(ACC_W-1).
  - When the accumulator would reach the shadow step value, it resets to 0 and a line is issued.
  - Negative accumulator (reverse travel) suppresses lines until forward travel recovers the debt.
- Line issue:
  - If CAP_READY=1, TRIG=1 for exactly one cycle.
  - Otherwise TRIG stays 0, MISSED_CNT increments (saturating) and OVERRUN is set.
  - LINE_CNT increments in both cases and wraps in continuous mode.
- When LINE_CNT reaches a nonzero shadow line count, go to DONE; no further lines are issued.
- DONE: DONE=1 for one cycle, then IDLE. Counters hold their values until the next START.
- ABORT in ARM or SCAN: go to IDLE on the next edge. No TRIG or DONE that cycle; counters hold.
  - ABORT has priority over a same-cycle line issue.
- BUSY is a registered decode of ARM|SCAN.
- Config inputs changed mid-scan have no effect until the next START.

Test Plan:
- Reset then idle: assert RST mid-scan -> all outputs 0 immediately, FSM IDLE; 10 forward pulses after release -> POS=10, TRIG never high.
- Basic scan: START_POS=0, STEP=4, LINES=3, CAP_READY=1, 8 forward pulses -> TRIG at SCAN entry, after pulse 4 and after pulse 8 (5 cycles after pulse 8 sampled); DONE pulse; LINE_CNT=3, MISSED_CNT=0.
- Arm wait: POS=-5, START_POS=3 -> BUSY=1, no TRIG for 7 pulses; TRIG on 8th pulse (POS=3).
- Reverse travel: STEP=4, after line 0 apply 2 fwd, 3 rev, 5 fwd -> next TRIG only after the 5th forward pulse (accumulator path 2, -1, 4).
- Overrun: CAP_READY=0 while a line is due -> no TRIG, MISSED_CNT=1, OVERRUN=1, LINE_CNT incremented; new START clears OVERRUN.
- Edge cases: simultaneous inc/dec -> POS unchanged; STEP=0 -> TRIG every pulse; ABORT same cycle as a due line -> no TRIG, IDLE next cycle, BUSY=0; START while BUSY ignored.
